core_io_regs: RTL and testbench
===============================

Name: core_io_regs

Overview:
Holds the core-internal I/O registers: SPL, SPH, SREG, RAMPZ and EIND.
- Accepts I/O-space writes from the core data bus.
- Takes per-bit flag updates from the ALU, interrupt-flag control from the interrupt/RETI logic, and push/pop stack-pointer steps from the instruction decoder.
- Its registered outputs feed the core's I/O read multiplexer directly (spl_out, sph_out, sreg_out, rampz_out, eind_out).

Parameters:
pc22b, 0, 1 = EIND implemented (22-bit PC); 0 = EIND absent, eind_out tied to 8'h00, writes to EIND ignored.
sph_impl, 1, 1 = 16-bit SP; 0 = 8-bit SP, sph_out tied to 8'h00, writes to SPH ignored, SP wraps at 8 bits.

Ports:
cp2  input  1  core clock; all state changes on its rising edge
ireset  input  1  asynchronous active-low reset
cpuwait  input  1  stall; when 1, no register changes state
adr  input  6  I/O address (SPL=0x3D, SPH=0x3E, SREG=0x3F, RAMPZ=0x3B, EIND=0x3C)
iowe  input  1  I/O write strobe
dbusout  input  8  write data from core
sreg_fl_in  input  8  new flag values from ALU
sreg_fl_wr_en  input  8  per-bit flag write enables
irq_ack  input  1  interrupt accepted; clears I (bit 7)
reti_st  input  1  RETI executing; sets I
sp_en  input  1  stack pointer step request
sp_ndown_up  input  1  0 = decrement (push), 1 = increment (pop)
spl_out  output  8  SP[7:0]
sph_out  output  8  SP[15:8]
sreg_out  output  8  SREG
rampz_out  output  8  RAMPZ
eind_out  output  8  EIND
sp_err  output  1  sticky SP wrap flag (optional feature only; 0 otherwise)

Behaviour:
- Reset: ireset low asynchronously forces SP, SREG, RAMPZ, EIND and sp_err to 0. It takes effect immediately, mid-operation included. The first update occurs on the first cp2 edge after release.
- All outputs come directly from flops. A write issued in cycle N is visible on the outputs in cycle N+1, with no combinational path from inputs to outputs.
- cpuwait=1: every input is ignored and all state holds, including the reset-released values.
- I/O write: with iowe=1, the register at address adr loads dbusout.
  - Addresses other than the five above are ignored.
  - EIND is writable only when pc22b=1; SPH only when sph_impl=1.
- SREG priority, highest first; the winner applies per bit:
  1. I/O write to 0x3F loads all 8 bits and masks every other SREG source that cycle.
  2. irq_ack clears bit 7.
  3. reti_st sets bit 7.
  4. sreg_fl_wr_en[i]=1 loads sreg_fl_in[i].
  - irq_ack and reti_st together: irq_ack wins (bit 7 = 0).
  - Bits 6:0 still take ALU updates in the same cycle as irq_ack/reti_st.
- SP step: sp_en=1 adds +1 (sp_ndown_up=1) or -1 (sp_ndown_up=0), modulo 2^16 (2^8 when sph_impl=0).
  - Wrap is silent: 0x0000-1 = 0xFFFF; 0xFFFF+1 = 0x0000.
  - An I/O write to SPL or SPH in the same cycle takes priority. The addressed byte loads dbusout, the other byte holds, and the step is dropped.
- RAMPZ and EIND change only by I/O write.

Optional Feature:
Macro: CORE_IO_REGS_SP_ERR_EN.
- Defined: sp_err is set on any sp_en step that wraps, i.e. decrement from 0 or increment from the maximum (0xFFFF, or 0xFF when sph_impl=0).
  - sp_err stays set until reset or until an I/O write to SPL/SPH.
  - If a wrap and a clearing write coincide, the write is the winner and clears sp_err (no step is taken).
- Undefined: no sp_err logic; sp_err is tied to 0.

Test Plan:
1. Reset, then I/O writes 0x3D<=0xFF, 0x3E<=0x10, 0x3B<=0x01, 0x3C<=0x02 (pc22b=0) -> spl_out=0xFF, sph_out=0x10, rampz_out=0x01, eind_out=0x00, each one cycle after its write.
2. SP=0x10FF; one sp_en increment -> 0x1100. Then two decrements -> 0x10FE. With SP=0x0000, decrement -> 0xFFFF, and sp_err=1 when the macro is defined.
3. sreg_fl_wr_en=0x03, sreg_fl_in=0xFF -> sreg_out=0x03. Next cycle, I/O write 0x3F<=0x80 together with sreg_fl_wr_en=0xFF, fl_in=0x00 -> sreg_out=0x80.
4. SREG=0x80; assert irq_ack and reti_st together with fl_wr_en=0x01, fl_in=0x01 -> sreg_out=0x01. Then reti_st alone -> 0x81.
5. SP=0x0200; I/O write SPL<=0x55 together with a sp_en decrement -> SP=0x0255. With cpuwait=1 during any write -> no output change.
6. Assert ireset mid-sequence between cp2 edges -> all outputs 0 immediately, without waiting for a clock edge. sph_impl=0: SP=0xFF, increment -> spl_out=0x00, sph_out=0x00.

Source files
------------

// File: rtl/core_io_regs_if.sv
// Bus bundle for core_io_regs: I/O write port, ALU/interrupt/decoder controls and
// the registered read-back values that go to the core's I/O read multiplexer.
interface core_io_regs_if;
  logic       cpuwait;
  logic [5:0] adr;
  logic       iowe;
  logic [7:0] dbusout;
  logic [7:0] sreg_fl_in;
  logic [7:0] sreg_fl_wr_en;
  logic       irq_ack;
  logic       reti_st;
  logic       sp_en;
  logic       sp_ndown_up;
  logic [7:0] spl_out;
  logic [7:0] sph_out;
  logic [7:0] sreg_out;
  logic [7:0] rampz_out;
  logic [7:0] eind_out;
  logic       sp_err;

  modport slave (
    input  cpuwait, adr, iowe, dbusout, sreg_fl_in, sreg_fl_wr_en,
           irq_ack, reti_st, sp_en, sp_ndown_up,
    output spl_out, sph_out, sreg_out, rampz_out, eind_out, sp_err
  );

  modport master (
    output cpuwait, adr, iowe, dbusout, sreg_fl_in, sreg_fl_wr_en,
           irq_ack, reti_st, sp_en, sp_ndown_up,
    input  spl_out, sph_out, sreg_out, rampz_out, eind_out, sp_err
  );
endinterface

// File: rtl/core_io_regs.sv
// Core-internal I/O registers SPL/SPH/SREG/RAMPZ/EIND, all outputs straight from flops.
// Optional sticky stack-pointer wrap flag enabled by defining CORE_IO_REGS_SP_ERR_EN.
module core_io_regs #(
  parameter bit pc22b    = 1'b0,
  parameter bit sph_impl = 1'b1
) (
  input  logic          cp2,
  input  logic          ireset,
  core_io_regs_if.slave bus
);
  localparam logic [5:0] ADR_RAMPZ = 6'h3B;
  localparam logic [5:0] ADR_EIND  = 6'h3C;
  localparam logic [5:0] ADR_SPL   = 6'h3D;
  localparam logic [5:0] ADR_SPH   = 6'h3E;
  localparam logic [5:0] ADR_SREG  = 6'h3F;

  logic [15:0] sp_q, sp_d, sp_step;
  logic [7:0]  sreg_q, sreg_d;
  logic [7:0]  rampz_q, rampz_d;
  logic [7:0]  eind_q, eind_d;
  logic        wr_spl, wr_sph, wr_sreg, wr_rampz, wr_eind, sp_wr;

  // Unimplemented registers never see a write, so their flops stay at reset value.
  assign wr_spl   = bus.iowe && (bus.adr == ADR_SPL);
  assign wr_sph   = bus.iowe && (bus.adr == ADR_SPH) && sph_impl;
  assign wr_sreg  = bus.iowe && (bus.adr == ADR_SREG);
  assign wr_rampz = bus.iowe && (bus.adr == ADR_RAMPZ);
  assign wr_eind  = bus.iowe && (bus.adr == ADR_EIND) && pc22b;
  assign sp_wr    = wr_spl || wr_sph;

  always_comb begin
    sp_step = sp_q;
    if (sph_impl) begin
      sp_step = bus.sp_ndown_up ? (sp_q + 16'd1) : (sp_q - 16'd1);
    end else begin
      sp_step = {8'h00, (bus.sp_ndown_up ? (sp_q[7:0] + 8'd1) : (sp_q[7:0] - 8'd1))};
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (wr_spl) sp_d[7:0] = bus.dbusout;
    if (wr_sph) sp_d[15:8] = bus.dbusout;
    if (!sp_wr && bus.sp_en) sp_d = sp_step;
  end

  // Bit 7 arbitration sits above the ALU per-bit load; an SREG write beats everything.
  always_comb begin
    sreg_d = (sreg_q & ~bus.sreg_fl_wr_en) | (bus.sreg_fl_in & bus.sreg_fl_wr_en);
    if (bus.irq_ack)      sreg_d[7] = 1'b0;
    else if (bus.reti_st) sreg_d[7] = 1'b1;
    if (wr_sreg) sreg_d = bus.dbusout;
  end

  assign rampz_d = wr_rampz ? bus.dbusout : rampz_q;
  assign eind_d  = wr_eind  ? bus.dbusout : eind_q;

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sp_q    <= 16'h0000;
      sreg_q  <= 8'h00;
      rampz_q <= 8'h00;
      eind_q  <= 8'h00;
    end else if (!bus.cpuwait) begin
      sp_q    <= sp_d;
      sreg_q  <= sreg_d;
      rampz_q <= rampz_d;
      eind_q  <= eind_d;
    end
  end

`ifdef CORE_IO_REGS_SP_ERR_EN
  logic sp_err_q, sp_err_d, sp_wrap;

  always_comb begin
    sp_wrap = 1'b0;
    if (bus.sp_en) begin
      if (bus.sp_ndown_up) sp_wrap = sph_impl ? (sp_q == 16'hFFFF) : (sp_q[7:0] == 8'hFF);
      else                 sp_wrap = sph_impl ? (sp_q == 16'h0000) : (sp_q[7:0] == 8'h00);
    end
    sp_err_d = sp_err_q;
    if (sp_wr)        sp_err_d = 1'b0;
    else if (sp_wrap) sp_err_d = 1'b1;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)           sp_err_q <= 1'b0;
    else if (!bus.cpuwait) sp_err_q <= sp_err_d;
  end

  assign bus.sp_err = sp_err_q;
`else
  assign bus.sp_err = 1'b0;
`endif

  assign bus.spl_out   = sp_q[7:0];
  assign bus.sph_out   = sp_q[15:8];
  assign bus.sreg_out  = sreg_q;
  assign bus.rampz_out = rampz_q;
  assign bus.eind_out  = eind_q;
endmodule

// File: tb/tb_core_io_regs.sv
// Scoreboard bench: two instances (16-bit SP without EIND, 8-bit SP with EIND) driven
// identically; a behavioural model predicts both, a monitor pops and compares.
module tb_core_io_regs;
`ifdef CORE_IO_REGS_SP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] spl, sph, sreg, rampz, eind;
    logic       err;
  } st_t;

  typedef struct {
    st_t a;
    st_t b;
  } exp_t;

  logic cp2 = 1'b0;
  logic ireset = 1'b0;
  always #5 cp2 = ~cp2;

  logic       cpuwait = 1'b0, iowe = 1'b0, irq = 1'b0, reti = 1'b0, spen = 1'b0, dir = 1'b0;
  logic [5:0] adr = 6'h00;
  logic [7:0] dbus = 8'h00, fl_in = 8'h00, fl_en = 8'h00;

  core_io_regs_if bus_a ();
  core_io_regs_if bus_b ();

  assign bus_a.cpuwait = cpuwait;  assign bus_b.cpuwait = cpuwait;
  assign bus_a.adr = adr;          assign bus_b.adr = adr;
  assign bus_a.iowe = iowe;        assign bus_b.iowe = iowe;
  assign bus_a.dbusout = dbus;     assign bus_b.dbusout = dbus;
  assign bus_a.sreg_fl_in = fl_in; assign bus_b.sreg_fl_in = fl_in;
  assign bus_a.sreg_fl_wr_en = fl_en; assign bus_b.sreg_fl_wr_en = fl_en;
  assign bus_a.irq_ack = irq;      assign bus_b.irq_ack = irq;
  assign bus_a.reti_st = reti;     assign bus_b.reti_st = reti;
  assign bus_a.sp_en = spen;       assign bus_b.sp_en = spen;
  assign bus_a.sp_ndown_up = dir;  assign bus_b.sp_ndown_up = dir;

  core_io_regs #(.pc22b(1'b0), .sph_impl(1'b1)) dut_a (.cp2(cp2), .ireset(ireset), .bus(bus_a));
  core_io_regs #(.pc22b(1'b1), .sph_impl(1'b0)) dut_b (.cp2(cp2), .ireset(ireset), .bus(bus_b));

  exp_t exp_q[$];
  st_t  ma, mb;
  int   checks = 0;
  int   errors = 0;
  event async_ev;

  function automatic st_t zero_st();
    st_t z;
    z.spl = 8'h00; z.sph = 8'h00; z.sreg = 8'h00; z.rampz = 8'h00; z.eind = 8'h00; z.err = 1'b0;
    return z;
  endfunction

  function automatic st_t model_next(st_t s, bit has_eind, bit sp16);
    st_t n = s;
    int  modulus = sp16 ? 65536 : 256;
    int  sp = sp16 ? int'({s.sph, s.spl}) : int'(s.spl);
    bit  wl, wh;
    if (!ireset) return zero_st();
    if (cpuwait) return s;
    wl = iowe && adr == 6'h3D;
    wh = iowe && adr == 6'h3E && sp16;
    if (wl || wh) begin
      if (wl) n.spl = dbus;
      if (wh) n.sph = dbus;
      n.err = 1'b0;
    end else if (spen) begin
      if (dir && sp == modulus - 1) n.err = ERR_EN;
      if (!dir && sp == 0) n.err = ERR_EN;
      sp = dir ? (sp + 1) % modulus : (sp + modulus - 1) % modulus;
      n.spl = sp[7:0];
      n.sph = sp[15:8];
    end
    if (iowe && adr == 6'h3F) n.sreg = dbus;
    else begin
      for (int i = 0; i < 8; i++) if (fl_en[i]) n.sreg[i] = fl_in[i];
      if (irq) n.sreg[7] = 1'b0;
      else if (reti) n.sreg[7] = 1'b1;
    end
    if (iowe && adr == 6'h3B) n.rampz = dbus;
    if (iowe && adr == 6'h3C && has_eind) n.eind = dbus;
    return n;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%02h required=%02h", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge cp2 or async_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_spl", bus_a.spl_out, e.a.spl);     chk("b_spl", bus_b.spl_out, e.b.spl);
        chk("a_sph", bus_a.sph_out, e.a.sph);     chk("b_sph", bus_b.sph_out, e.b.sph);
        chk("a_sreg", bus_a.sreg_out, e.a.sreg);  chk("b_sreg", bus_b.sreg_out, e.b.sreg);
        chk("a_rampz", bus_a.rampz_out, e.a.rampz); chk("b_rampz", bus_b.rampz_out, e.b.rampz);
        chk("a_eind", bus_a.eind_out, e.a.eind);  chk("b_eind", bus_b.eind_out, e.b.eind);
        chk("a_sp_err", {7'd0, bus_a.sp_err}, {7'd0, e.a.err});
        chk("b_sp_err", {7'd0, bus_b.sp_err}, {7'd0, e.b.err});
      end
    end
  end

  task automatic idle();
    cpuwait = 1'b0; iowe = 1'b0; irq = 1'b0; reti = 1'b0; spen = 1'b0; dir = 1'b0;
    adr = 6'h00; dbus = 8'h00; fl_in = 8'h00; fl_en = 8'h00;
  endtask

  // Predict the edge, queue it, then let the edge happen.
  task automatic cyc();
    exp_t e;
    ma = model_next(ma, 1'b0, 1'b1);
    mb = model_next(mb, 1'b1, 1'b0);
    e.a = ma; e.b = mb;
    exp_q.push_back(e);
    @(posedge cp2);
    @(negedge cp2);
  endtask

  task automatic io_wr(logic [5:0] a, logic [7:0] d);
    idle(); iowe = 1'b1; adr = a; dbus = d; cyc();
  endtask

  task automatic step_sp(logic up);
    idle(); spen = 1'b1; dir = up; cyc();
  endtask

  task automatic async_reset();
    exp_t e;
    #2;
    ireset = 1'b0;
    ma = zero_st(); mb = zero_st();
    e.a = ma; e.b = mb;
    exp_q.push_back(e);
    -> async_ev;
    @(negedge cp2);
    cyc();
    ireset = 1'b1;
  endtask

  initial begin
    int r;
    idle();
    ma = zero_st(); mb = zero_st();
    @(negedge cp2);
    async_reset();

    io_wr(6'h3D, 8'hFF); io_wr(6'h3E, 8'h10); io_wr(6'h3B, 8'h01); io_wr(6'h3C, 8'h02);
    step_sp(1'b1); step_sp(1'b0); step_sp(1'b0);
    io_wr(6'h3D, 8'h00); io_wr(6'h3E, 8'h00); step_sp(1'b0);
    io_wr(6'h3D, 8'hFF); step_sp(1'b1);

    idle(); fl_en = 8'h03; fl_in = 8'hFF; cyc();
    idle(); iowe = 1'b1; adr = 6'h3F; dbus = 8'h80; fl_en = 8'hFF; fl_in = 8'h00; cyc();
    idle(); irq = 1'b1; reti = 1'b1; fl_en = 8'h01; fl_in = 8'h01; cyc();
    idle(); reti = 1'b1; cyc();

    io_wr(6'h3E, 8'h02); io_wr(6'h3D, 8'h00);
    idle(); iowe = 1'b1; adr = 6'h3D; dbus = 8'h55; spen = 1'b1; dir = 1'b0; cyc();
    idle(); cpuwait = 1'b1; iowe = 1'b1; adr = 6'h3B; dbus = 8'hAA; spen = 1'b1; cyc();
    idle(); cpuwait = 1'b1; iowe = 1'b1; adr = 6'h3F; dbus = 8'h3C; fl_en = 8'hFF; cyc();

    async_reset();

    for (int n = 0; n < 600; n++) begin
      idle();
      r = $urandom_range(0, 7);
      adr = (r < 5) ? 6'(6'h3B + r) : 6'($urandom_range(0, 63));
      iowe = ($urandom_range(0, 2) == 0);
      dbus = 8'($urandom);
      fl_in = 8'($urandom);
      fl_en = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
      irq = ($urandom_range(0, 7) == 0);
      reti = ($urandom_range(0, 7) == 0);
      spen = ($urandom_range(0, 1) == 0);
      dir = $urandom_range(0, 1);
      cpuwait = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      else cyc();
    end

    idle();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge cp2);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
